// File: rtl/addsub_pkg.sv
// Shared types and helpers for the serial chunked adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the chunk index; a single-chunk datapath still needs one bit.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// CHUNK-bit ripple slice built from 1-bit full adders; also exposes the carry
// into its top bit so the caller can form signed overflow on the last chunk.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder_1bit u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[CHUNK];
    assign cmsb = c[CHUNK-1];
endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle two's-complement add/sub: WIDTH bits processed CHUNK bits per
// cycle through one shared slice, with optional signed saturation.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Ovfl,
    output logic             Neg,
    output logic             Zero,
    output state_t           dbg_state_o
);
    // WIDTH must be a multiple of CHUNK.
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = idx_width(NCHUNK);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    state_t state_q, state_d;
    logic             accept;
    logic             last_chunk;

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             c_q, c_d, sat_q, sat_d, sa_q, sa_d;
    logic             ovfl_q, ovfl_d, neg_q, neg_d, zero_q, zero_d;

    logic [CHUNK-1:0] sl_a, sl_b, sl_s;
    logic             sl_cout, sl_cmsb, ovfl_now;
    logic [WIDTH-1:0] raw, sat_val, final_res;

    // Valid/ready: a transfer happens on any edge where valid & ready are both
    // high; the producer holds its payload stable until then, and the result
    // stays stable while out_valid is high and out_ready is low.

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (last_chunk) state_d = DONE;
            DONE:    if (out_ready) state_d = in_valid ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // in_ready in DONE is combinational from out_ready so the next op overlaps.
    always_comb begin
        in_ready    = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        out_valid   = (state_q == DONE);
        accept      = in_valid && in_ready;
        dbg_state_o = state_q;
    end

    assign last_chunk = (state_q == BUSY) && (idx_q == LAST_IDX);

    assign sl_a = a_q[idx_q*CHUNK +: CHUNK];
    assign sl_b = b_q[idx_q*CHUNK +: CHUNK];

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (c_q),
        .s    (sl_s),
        .cout (sl_cout),
        .cmsb (sl_cmsb)
    );

    always_comb begin
        raw = res_q;
        raw[idx_q*CHUNK +: CHUNK] = sl_s;
    end

    assign ovfl_now  = sl_cmsb ^ sl_cout;
    assign sat_val   = sa_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    assign final_res = (sat_q && ovfl_now) ? sat_val : raw;

    // Subtraction is A + ~B + 1: B is inverted at accept and the +1 rides in c_q.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        idx_d  = idx_q;
        sat_d  = sat_q;
        sa_d   = sa_q;
        res_d  = res_q;
        ovfl_d = ovfl_q;
        neg_d  = neg_q;
        zero_d = zero_q;
        if (accept) begin
            a_d   = A;
            b_d   = sub ? ~B : B;
            c_d   = sub;
            idx_d = '0;
            sat_d = sat;
            sa_d  = A[WIDTH-1];
        end else if (state_q == BUSY) begin
            c_d = sl_cout;
            if (last_chunk) begin
                res_d  = final_res;
                ovfl_d = ovfl_now;
                neg_d  = final_res[WIDTH-1];
                zero_d = (final_res == '0);
                idx_d  = '0;
            end else begin
                res_d = raw;
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= 1'b0;
            idx_q  <= '0;
            sat_q  <= 1'b0;
            sa_q   <= 1'b0;
            res_q  <= '0;
            ovfl_q <= 1'b0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            idx_q  <= idx_d;
            sat_q  <= sat_d;
            sa_q   <= sa_d;
            res_q  <= res_d;
            ovfl_q <= ovfl_d;
            neg_q  <= neg_d;
            zero_q <= zero_d;
        end
    end

    assign Sum  = res_q;
    assign Ovfl = ovfl_q;
    assign Neg  = neg_q;
    assign Zero = zero_q;

endmodule
